// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive bit-timing path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package usb_rx_pkg;

  // Default bit timing: 8 clocks per bit, sample taken at phase 3.
  localparam int CLKS_PER_BIT = 8;
  localparam int SAMPLE_PHASE = 3;

  // After this many consecutive ones the transmitter inserts a stuffed zero.
  localparam int STUFF_LIMIT  = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

endpackage

// File: rtl/rx_bit_timer_if.sv
// Bundle of line-side inputs and shift-register control outputs of the bit timer.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are single-cycle pulses or levels.
//   d_edge/rcving/d_orig : driven by edge detector, RX FSM and NRZI decoder
//   shift_enable/byte_received/stuff_err : driven by the bit timer
interface rx_bit_timer_if;

  logic d_edge;
  logic rcving;
  logic d_orig;
  logic shift_enable;
  logic byte_received;
  logic stuff_err;

  // Upstream side (edge detector / RX FSM / decoder / shift register).
  modport master (
    output d_edge,
    output rcving,
    output d_orig,
    input  shift_enable,
    input  byte_received,
    input  stuff_err
  );

  // Bit timer side.
  modport slave (
    input  d_edge,
    input  rcving,
    input  d_orig,
    output shift_enable,
    output byte_received,
    output stuff_err
  );

endinterface

// File: rtl/rx_phase_counter.sv
// 3-bit bit-phase counter with synchronous clear, load-to-1 and mod-N wrap.
// Latency: count updates one clock after clr/load_one/run.
// Backpressure: none.
//   clr      : force count to 0 (highest priority)
//   load_one : resynchronise, count becomes 1
//   run      : advance mod MODULUS; when neither load_one nor run, count returns to 0
module rx_phase_counter #(
  parameter int MODULUS = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clr,
  input  logic       load_one,
  input  logic       run,
  output logic [2:0] cnt
);

  localparam logic [2:0] LAST = 3'(MODULUS - 1);

  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = 3'd0;
    if (clr) begin
      cnt_d = 3'd0;
    end else if (load_one) begin
      // The edge cycle itself counts as phase 0, so the next cycle is phase 1.
      cnt_d = 3'd1;
    end else if (run) begin
      cnt_d = (cnt == LAST) ? 3'd0 : cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= 3'd0;
    end else begin
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_bit_timer.sv
// USB RX bit timer: recovers bit timing from line edges, drops stuffed bits, frames bytes.
// Latency: shift_enable/stuff_err combinational in the sample cycle; byte_received one clock later.
// Backpressure: none; the downstream shift register must accept every shift_enable pulse.
//   clk, n_rst : clock and async active-low reset
//   bus.slave  : d_edge/rcving/d_orig in, shift_enable/byte_received/stuff_err out
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = usb_rx_pkg::CLKS_PER_BIT,
  parameter int SAMPLE_PHASE = usb_rx_pkg::SAMPLE_PHASE
) (
  input  logic          clk,
  input  logic          n_rst,
  rx_bit_timer_if.slave bus
);

  import usb_rx_pkg::state_t;
  import usb_rx_pkg::IDLE;
  import usb_rx_pkg::WAIT_EDGE;
  import usb_rx_pkg::ACTIVE;
  import usb_rx_pkg::STUFF_LIMIT;

  localparam logic [2:0] SAMPLE_CNT = 3'(SAMPLE_PHASE);
  localparam logic [2:0] STUFF_CNT  = 3'(STUFF_LIMIT);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] clk_cnt;
  logic [2:0] bit_cnt_q;
  logic [2:0] ones_cnt_q;
  logic       byte_rcvd_q;

  logic       sample;
  logic       stuffed;
  logic       shift_en;
  logic       resync;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.rcving) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:      state_d = WAIT_EDGE;
        WAIT_EDGE: if (bus.d_edge) state_d = ACTIVE;
        ACTIVE:    state_d = ACTIVE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // ---------------- bit phase ----------------
  // Edges only matter once the receiver is armed; in IDLE they are ignored.
  assign resync = bus.d_edge && ((state_q == WAIT_EDGE) || (state_q == ACTIVE));

  rx_phase_counter #(
    .MODULUS (CLKS_PER_BIT)
  ) u_phase (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (!bus.rcving),
    .load_one (resync),
    .run      (state_q == ACTIVE),
    .cnt      (clk_cnt)
  );

  // ---------------- sampling / destuffing ----------------
  // An edge in the sample cycle only reloads the phase; the sample itself still happens.
  assign sample   = (state_q == ACTIVE) && bus.rcving && (clk_cnt == SAMPLE_CNT);
  assign stuffed  = sample && (ones_cnt_q == STUFF_CNT);
  assign shift_en = sample && !stuffed;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt_q  <= 3'd0;
      ones_cnt_q <= 3'd0;
    end else if (!bus.rcving) begin
      // Dropping rcving discards any partial byte.
      bit_cnt_q  <= 3'd0;
      ones_cnt_q <= 3'd0;
    end else begin
      if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (sample) begin
        ones_cnt_q <= (stuffed || !bus.d_orig) ? 3'd0 : ones_cnt_q + 3'd1;
      end
    end
  end

  // Registered so the pulse survives rcving falling in the following cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_rcvd_q <= 1'b0;
    end else begin
      byte_rcvd_q <= shift_en && (bit_cnt_q == 3'd7);
    end
  end

  assign bus.shift_enable  = shift_en;
  assign bus.byte_received = byte_rcvd_q;
  assign bus.stuff_err     = stuffed && bus.d_orig;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Randomised and directed checks of rx_bit_timer against a timestamp-based reference model.
module tb_rx_bit_timer;

  localparam int BIT_CLKS = 8;
  localparam int SAMP     = 3;
  localparam int STUFF    = 6;

  logic clk;
  logic n_rst;

  rx_bit_timer_if bus ();

  rx_bit_timer #(
    .CLKS_PER_BIT (BIT_CLKS),
    .SAMPLE_PHASE (SAMP)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state: expressed as "time of last accepted edge" plus
  // run-length counters, not as a phase counter or FSM.
  bit prev_rcv  = 1'b0;
  bit synced    = 1'b0;
  int last_edge = 0;
  int ones_run  = 0;
  int nbits     = 0;
  bit byte_pend = 1'b0;

  // Observed pulse counters for segment-level checks.
  int obs_se    = 0;
  int obs_br    = 0;
  int obs_err   = 0;
  int first_se  = -1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check mid-cycle, advance model.
  task automatic step(input logic e, input logic r, input logic d, input logic rn);
    bit exp_se;
    bit exp_err;
    bit exp_br;
    bit new_pend;
    @(posedge clk);
    #1;
    n_rst      = rn;
    bus.d_edge = e;
    bus.rcving = r;
    bus.d_orig = d;
    #3;
    exp_se   = 1'b0;
    exp_err  = 1'b0;
    exp_br   = byte_pend && rn;
    new_pend = 1'b0;
    if (rn) begin
      if (synced && r && (((cyc - last_edge) % BIT_CLKS) == SAMP)) begin
        if (ones_run == STUFF) begin
          exp_err  = d;
          ones_run = 0;
        end else begin
          exp_se   = 1'b1;
          ones_run = d ? ones_run + 1 : 0;
          nbits++;
          if (nbits == 8) begin
            nbits    = 0;
            new_pend = 1'b1;
          end
        end
      end
    end
    check_eq("shift_enable", int'(bus.shift_enable), int'(exp_se));
    check_eq("stuff_err", int'(bus.stuff_err), int'(exp_err));
    check_eq("byte_received", int'(bus.byte_received), int'(exp_br));
    if (bus.shift_enable) begin
      obs_se++;
      if (first_se < 0) first_se = cyc;
    end
    if (bus.byte_received) obs_br++;
    if (bus.stuff_err) obs_err++;
    if (!rn) begin
      synced    = 1'b0;
      ones_run  = 0;
      nbits     = 0;
      prev_rcv  = 1'b0;
      byte_pend = 1'b0;
    end else begin
      // The receiver is armed only if rcving was already high last cycle.
      if (e && r && prev_rcv) begin
        synced    = 1'b1;
        last_edge = cyc;
      end
      if (!r) begin
        synced   = 1'b0;
        ones_run = 0;
        nbits    = 0;
      end
      prev_rcv  = r;
      byte_pend = new_pend;
    end
    cyc++;
  endtask

  task automatic clear_obs();
    obs_se   = 0;
    obs_br   = 0;
    obs_err  = 0;
    first_se = -1;
  endtask

  // One bit period of length per, edge in its first cycle, d_orig held throughout.
  task automatic send_bit(input logic b, input int per);
    step(1'b1, 1'b1, b, 1'b1);
    for (int i = 1; i < per; i++) step(1'b0, 1'b1, b, 1'b1);
  endtask

  task automatic send_run(input logic b, input int n);
    for (int i = 0; i < n; i++) send_bit(b, BIT_CLKS);
  endtask

  int t_edge;
  int gap;
  int rcv_off;
  int rst_off;
  logic bval;
  logic e;
  logic r;
  logic rn;

  initial begin
    n_rst      = 1'b0;
    bus.d_edge = 1'b0;
    bus.rcving = 1'b0;
    bus.d_orig = 1'b0;

    // Reset state: all outputs low, even with inputs toggling.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Single edge, no further edges: samples at T+3, T+11, T+19, T+27.
    clear_obs();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("no_shift_before_edge", obs_se, 0);
    t_edge = cyc;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 30; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("single_edge_pulses", obs_se, 4);
    check_eq("first_sample_offset", first_se - t_edge, 3);

    // Eight zero bits with edges each bit: 8 shifts then one byte_received.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    clear_obs();
    send_run(1'b0, 8);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("byte_zero_shifts", obs_se, 8);
    check_eq("byte_zero_bytes", obs_br, 1);

    // Six ones then a stuffed 0: seventh bit is dropped silently.
    clear_obs();
    send_run(1'b1, 6);
    send_bit(1'b0, BIT_CLKS);
    check_eq("stuff0_shifts", obs_se, 6);
    check_eq("stuff0_err", obs_err, 0);

    // Six ones then a 1 in the stuffed slot: dropped and flagged.
    clear_obs();
    send_run(1'b1, 6);
    send_bit(1'b1, BIT_CLKS);
    check_eq("stuff1_shifts", obs_se, 6);
    check_eq("stuff1_err", obs_err, 1);

    // Early resync: edges every 5 clocks, one sample per bit.
    clear_obs();
    for (int i = 0; i < 6; i++) send_bit(1'b0, 5);
    check_eq("early_resync_shifts", obs_se, 6);

    // rcving dropped mid-byte, then a fresh byte.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    clear_obs();
    send_run(1'b0, 5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("drop_no_byte", obs_br, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    clear_obs();
    send_run(1'b0, 8);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("drop_restart_byte", obs_br, 1);

    // Reset mid-byte: waits for a new edge, then restarts the byte from bit 0.
    clear_obs();
    send_run(1'b0, 5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("rst_no_byte", obs_br, 0);
    clear_obs();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("rst_wait_edge", obs_se, 0);
    send_run(1'b0, 8);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("rst_restart_byte", obs_br, 1);

    // Randomised traffic: jittered edges, spurious edges, rcving drops, resets.
    gap     = 0;
    rcv_off = 0;
    rst_off = 0;
    bval    = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (gap == 0) begin
        e    = 1'b1;
        gap  = $urandom_range(11, 5);
        bval = ($urandom_range(3, 0) != 0);
      end else begin
        e = ($urandom_range(63, 0) == 0);
        gap--;
      end
      if (rcv_off > 0) begin
        r = 1'b0;
        rcv_off--;
      end else if ($urandom_range(299, 0) == 0) begin
        r       = 1'b0;
        rcv_off = $urandom_range(4, 1);
      end else begin
        r = 1'b1;
      end
      if (rst_off > 0) begin
        rn = 1'b0;
        rst_off--;
      end else if ($urandom_range(1499, 0) == 0) begin
        rn      = 1'b0;
        rst_off = 1;
      end else begin
        rn = 1'b1;
      end
      step(e, r, bval, rn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
